// File: rtl/modport_router.sv
// 1x3 byte-serial packet router: header-addressed steering into three FIFOs with parity check.
// Optional ROUTER_SOFT_RESET_EN flushes a destination FIFO left unread for TIMEOUT cycles.
module modport_router #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] data_in,
  input  logic       pkt_valid,
  output logic       busy,
  output logic       error,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       valid_out_2
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 || TIMEOUT < 2) begin : g_param_check
    $error("modport_router: FIFO_DEPTH must be a power of two and TIMEOUT at least 2");
  end

  typedef enum logic [2:0] {
    DECODE, WAIT_EMPTY, LOAD_DATA, FIFO_FULL, LOAD_PARITY, CHECK_PARITY
  } state_t;

  state_t state, state_d;

  logic [8:0]    mem    [3][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [3];
  logic [AW-1:0] rd_ptr [3];
  logic [AW:0]   count  [3];
  logic [7:0]    dout   [3];

  // Index 3 is a phantom destination for the invalid address: always empty, never full.
  logic [3:0] empty_v, full_v, rd_v, flush_v, wr_onehot;
  logic [2:0] wr_en, rd_en;

  logic [1:0] tgt, sel;
  logic       discard;
  logic [7:0] hold, parity;
  logic       we, ld_hold, par_init, par_xor, accept, clr_err, chk_err, wr_ok;
  logic [8:0] wr_word;

  assign rd_v = {1'b0, read_enb_2, read_enb_1, read_enb_0};

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    empty_v = 4'b1000;
    full_v  = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      empty_v[n] = (count[n] == '0);
      full_v[n]  = (count[n] == (AW+1)'(FIFO_DEPTH));
    end
  end

  assign rd_en     = rd_v[2:0] & ~empty_v[2:0];
  assign wr_onehot = 4'b0001 << sel;
  assign wr_en     = we ? wr_onehot[2:0] : 3'b000;

  // NOTE: the storage array carries no reset; pointers and count alone define what is valid.
  always_ff @(posedge clock) begin
    for (int n = 0; n < 3; n++)
      if (wr_en[n]) mem[n][wr_ptr[n]] <= wr_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      for (int n = 0; n < 3; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
        dout[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (flush_v[n]) begin
          wr_ptr[n] <= '0;
          rd_ptr[n] <= '0;
          count[n]  <= '0;
          dout[n]   <= '0;
        end else begin
          if (wr_en[n]) wr_ptr[n] <= wr_ptr[n] + 1'b1;
          if (rd_en[n]) begin
            rd_ptr[n] <= rd_ptr[n] + 1'b1;
            dout[n]   <= mem[n][rd_ptr[n]][7:0];
          end
          count[n] <= count[n] + (AW+1)'(wr_en[n]) - (AW+1)'(rd_en[n]);
        end
      end
    end
  end

`ifdef ROUTER_SOFT_RESET_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt [3];

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      for (int n = 0; n < 3; n++) idle_cnt[n] <= '0;
    end else begin
      for (int n = 0; n < 3; n++)
        if (empty_v[n] || rd_v[n]) idle_cnt[n] <= '0;
        else                       idle_cnt[n] <= idle_cnt[n] + 1'b1;
    end
  end

  always_comb begin
    flush_v = 4'b0000;
    for (int n = 0; n < 3; n++)
      flush_v[n] = !empty_v[n] && !rd_v[n] && (idle_cnt[n] == CW'(TIMEOUT - 1));
  end
`else
  assign flush_v = 4'b0000;
`endif

  // In DECODE the target is still on data_in; afterwards it is the latched header address.
  assign sel   = (state == DECODE) ? data_in[1:0] : tgt;
  assign wr_ok = !full_v[sel] || rd_v[sel];

  always_comb begin
    state_d  = state;
    we       = 1'b0;
    wr_word  = {1'b0, hold};
    ld_hold  = 1'b0;
    par_init = 1'b0;
    par_xor  = 1'b0;
    accept   = 1'b0;
    clr_err  = 1'b0;
    chk_err  = 1'b0;
    case (state)
      DECODE: if (pkt_valid) begin
        accept = 1'b1;
        if (data_in[1:0] == 2'd3) begin
          state_d = LOAD_DATA;
        end else if (empty_v[sel]) begin
          we       = 1'b1;
          wr_word  = {1'b1, data_in};
          par_init = 1'b1;
          clr_err  = 1'b1;
          state_d  = LOAD_DATA;
        end else begin
          ld_hold  = 1'b1;
          par_init = 1'b1;
          state_d  = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: if (empty_v[sel]) begin
        we      = 1'b1;
        wr_word = {1'b1, hold};
        clr_err = 1'b1;
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (!pkt_valid) begin
          ld_hold = 1'b1;
          state_d = LOAD_PARITY;
        end else if (discard || wr_ok) begin
          we      = !discard;
          wr_word = {1'b0, data_in};
          par_xor = 1'b1;
        end else begin
          // Byte already taken from the source; park it until the FIFO drains.
          ld_hold = 1'b1;
          par_xor = 1'b1;
          state_d = FIFO_FULL;
        end
      end
      FIFO_FULL: if (wr_ok) begin
        we = 1'b1;
        if (pkt_valid) begin
          state_d = LOAD_DATA;
        end else begin
          ld_hold = 1'b1;
          state_d = LOAD_PARITY;
        end
      end
      LOAD_PARITY: if (discard || wr_ok) begin
        we      = !discard;
        state_d = CHECK_PARITY;
      end
      CHECK_PARITY: begin
        chk_err = !discard;
        state_d = DECODE;
      end
      default: state_d = DECODE;
    endcase
    if (state != DECODE && flush_v[sel]) begin
      we      = 1'b0;
      chk_err = 1'b0;
      state_d = DECODE;
    end
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state   <= DECODE;
      tgt     <= 2'd0;
      discard <= 1'b0;
      hold    <= '0;
      parity  <= '0;
      error   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        tgt     <= data_in[1:0];
        discard <= (data_in[1:0] == 2'd3);
      end
      if (ld_hold)       hold   <= data_in;
      if (par_init)      parity <= data_in;
      else if (par_xor)  parity <= parity ^ data_in;
      if (clr_err)       error  <= 1'b0;
      else if (chk_err)  error  <= (parity != hold);
    end
  end

  assign busy = (state == WAIT_EMPTY) || (state == FIFO_FULL) ||
                (state == LOAD_PARITY) || (state == CHECK_PARITY);

  assign data_out_0  = dout[0];
  assign data_out_1  = dout[1];
  assign data_out_2  = dout[2];
  assign valid_out_0 = !empty_v[0];
  assign valid_out_1 = !empty_v[1];
  assign valid_out_2 = !empty_v[2];

endmodule

// File: tb/tb_modport_router.sv
// Directed self-checking bench for modport_router; soft-reset step runs when ROUTER_SOFT_RESET_EN is defined.
module tb_modport_router;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       busy, error;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       valid_out_0, valid_out_1, valid_out_2;

  int checks = 0;
  int errors = 0;

  logic [7:0] pay [1:20];
  logic [7:0] exp_stream [22];
  logic [7:0] rx [22];
  logic [7:0] par;
  int         got;

  modport_router #(.FIFO_DEPTH(16), .TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn), .data_in(data_in), .pkt_valid(pkt_valid),
    .busy(busy), .error(error),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1), .valid_out_2(valid_out_2)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present a byte and hold it until the router accepts it on an edge with busy low.
  task automatic put(input logic [7:0] b, input logic pv);
    int n;
    data_in   = b;
    pkt_valid = pv;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (busy) check("busy_stuck", busy, 0);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] dout_of(input int port);
    case (port)
      0:       return data_out_0;
      1:       return data_out_1;
      default: return data_out_2;
    endcase
  endfunction

  task automatic read_one(input int port, input logic [7:0] expected, input string tag);
    case (port)
      0:       read_enb_0 = 1'b1;
      1:       read_enb_1 = 1'b1;
      default: read_enb_2 = 1'b1;
    endcase
    @(posedge clock);
    #1;
    read_enb_0 = 1'b0;
    read_enb_1 = 1'b0;
    read_enb_2 = 1'b0;
    check(tag, dout_of(port), expected);
  endtask

  initial begin
    resetn = 1'b1; data_in = 8'h00; pkt_valid = 1'b0;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    step(2);
    resetn = 1'b0;
    step(1);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_valid", {valid_out_2, valid_out_1, valid_out_0}, 0);
    check("rst_dout", {data_out_2, data_out_1, data_out_0}, 0);

    // Asynchronous reset mid-packet aborts it
    put(8'h0D, 1'b1);
    put(8'h11, 1'b1);
    check("midpkt_valid1", valid_out_1, 1);
    #2 resetn = 1'b1;
    #1;
    check("async_rst_valid1", valid_out_1, 0);
    check("async_rst_busy", busy, 0);
    pkt_valid = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b0;
    step(1);

    // Good packet to FIFO 1
    put(8'h0D, 1'b1);
    check("hdr_write_latency", valid_out_1, 1);
    put(8'h11, 1'b1);
    put(8'h22, 1'b1);
    put(8'h33, 1'b1);
    put(8'h0D, 1'b0);
    step(2);
    check("good_error", error, 0);
    check("good_busy", busy, 0);
    check("good_other_valid", {valid_out_2, valid_out_0}, 0);
    read_one(1, 8'h0D, "good_rd_hdr");
    read_one(1, 8'h11, "good_rd_p1");
    read_one(1, 8'h22, "good_rd_p2");
    read_one(1, 8'h33, "good_rd_p3");
    read_one(1, 8'h0D, "good_rd_par");
    check("good_drained", valid_out_1, 0);

    // Bad parity: error rises two cycles after the parity byte
    put(8'h0D, 1'b1);
    put(8'h11, 1'b1);
    put(8'h22, 1'b1);
    put(8'h33, 1'b1);
    put(8'h0C, 1'b0);
    check("bad_err_t0", error, 0);
    step(1);
    check("bad_err_t1", error, 0);
    step(1);
    check("bad_err_t2", error, 1);
    check("bad_busy_done", busy, 0);

    // Invalid address 3: consumed, nothing stored, error unchanged
    put(8'h07, 1'b1);
    put(8'h99, 1'b1);
    put(8'h42, 1'b0);
    step(2);
    check("inv_error_held", error, 1);
    check("inv_no_write", {valid_out_2, valid_out_0}, 0);
    read_one(1, 8'h0D, "bad_rd_hdr");
    read_one(1, 8'h11, "bad_rd_p1");
    read_one(1, 8'h22, "bad_rd_p2");
    read_one(1, 8'h33, "bad_rd_p3");
    read_one(1, 8'h0C, "bad_rd_par");
    check("bad_drained", valid_out_1, 0);

    // Valid header clears error; second header to busy FIFO 2 waits for drain
    put(8'h06, 1'b1);
    check("err_cleared", error, 0);
    check("fifo2_valid", valid_out_2, 1);
    put(8'hA5, 1'b1);
    put(8'hA3, 1'b0);
    step(2);
    check("pktA_error", error, 0);
    put(8'h06, 1'b1);
    check("wait_empty_busy", busy, 1);
    data_in = 8'h5A;
    step(3);
    check("wait_empty_busy_held", busy, 1);
    read_one(2, 8'h06, "A_rd_hdr");
    read_one(2, 8'hA5, "A_rd_p1");
    read_one(2, 8'hA3, "A_rd_par");
    check("A_drained", valid_out_2, 0);
    put(8'h5A, 1'b1);
    put(8'h5C, 1'b0);
    step(2);
    check("pktB_error", error, 0);
    read_one(2, 8'h06, "B_rd_hdr");
    read_one(2, 8'h5A, "B_rd_p1");
    read_one(2, 8'h5C, "B_rd_par");

    // Length-20 packet to FIFO 0 overflows the 16-entry FIFO
    par = 8'h50;
    exp_stream[0] = 8'h50;
    for (int k = 1; k <= 20; k++) begin
      pay[k] = 8'(k * 29 + 3);
      par ^= pay[k];
      exp_stream[k] = pay[k];
    end
    exp_stream[21] = par;
    put(8'h50, 1'b1);
    for (int k = 1; k <= 15; k++) put(pay[k], 1'b1);
    check("full16_busy", busy, 0);
    check("full16_valid", valid_out_0, 1);
    data_in = pay[16];
    @(posedge clock);
    #1;
    check("overflow_busy", busy, 1);
    data_in = pay[17];
    step(3);
    check("overflow_busy_held", busy, 1);
    got = 0;
    fork
      begin
        for (int k = 17; k <= 20; k++) put(pay[k], 1'b1);
        put(par, 1'b0);
      end
      begin
        logic v;
        read_enb_0 = 1'b1;
        for (int c = 0; c < 300 && got < 22; c++) begin
          @(negedge clock);
          v = valid_out_0;
          @(posedge clock);
          #1;
          if (v) begin
            rx[got] = data_out_0;
            got++;
          end
        end
        read_enb_0 = 1'b0;
      end
    join
    step(3);
    check("len20_count", got, 22);
    for (int i = 0; i < 22; i++) check($sformatf("len20_byte%0d", i), rx[i], exp_stream[i]);
    check("len20_error", error, 0);
    check("len20_drained", valid_out_0, 0);
    check("len20_busy", busy, 0);

`ifdef ROUTER_SOFT_RESET_EN
    // Unread FIFO 0 is flushed after the idle timeout
    put(8'h04, 1'b1);
    put(8'h77, 1'b1);
    put(8'h73, 1'b0);
    step(2);
    read_one(0, 8'h04, "soft_rd_hdr");
    check("soft_pre_valid", valid_out_0, 1);
    step(40);
    check("soft_flush_valid", valid_out_0, 0);
    check("soft_flush_dout", data_out_0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
